// File: rtl/status_frame_pkg.sv
// status_frame_pkg
// Shared definitions for the motor-board status frame receiver:
//   - frame constants (start-of-frame marker, payload word count, CRC polynomial)
//   - field_e      : order of the 32-bit words inside a frame payload
//   - rx_state_e   : byte receiver states
//   - parser_state_e : frame parser states
//   - crc8_update  : one byte step of CRC-8 (poly 0x07, MSB first, no reflection)
package status_frame_pkg;

    localparam logic [7:0] SOF         = 8'hA5;
    localparam int         FRAME_WORDS = 8;
    localparam logic [7:0] CRC8_POLY   = 8'h07;

    typedef enum logic [2:0] {
        F_ENC0_POS = 3'd0,
        F_ENC1_POS = 3'd1,
        F_ENC0_VEL = 3'd2,
        F_ENC1_VEL = 3'd3,
        F_PHASE1   = 3'd4,
        F_PHASE2   = 3'd5,
        F_PHASE3   = 3'd6,
        F_ERROR    = 3'd7
    } field_e;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        HUNT,
        ID,
        PAYLOAD,
        CRC,
        COMMIT
    } parser_state_e;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/status_frame_rx_if.sv
// status_frame_rx_if
// Per-motor status bus between the frame receiver and the Avalon register file.
//   encoder0_position .. current_phase3 : signed 32-bit status words, one per motor
//   error_code     : 32-bit error word per motor
//   frame_valid    : one-cycle pulse on each committed frame
//   frame_motor    : motor id of the last committed frame
//   frames_ok      : committed-frame counter (wraps)
//   frames_dropped : discarded-frame counter (wraps)
// Modports: master = receiver (drives), slave = register file (reads).
interface status_frame_rx_if #(
    parameter int NUMBER_OF_MOTORS = 6
);
    logic signed [31:0] encoder0_position [NUMBER_OF_MOTORS];
    logic signed [31:0] encoder1_position [NUMBER_OF_MOTORS];
    logic signed [31:0] encoder0_velocity [NUMBER_OF_MOTORS];
    logic signed [31:0] encoder1_velocity [NUMBER_OF_MOTORS];
    logic signed [31:0] current_phase1    [NUMBER_OF_MOTORS];
    logic signed [31:0] current_phase2    [NUMBER_OF_MOTORS];
    logic signed [31:0] current_phase3    [NUMBER_OF_MOTORS];
    logic        [31:0] error_code        [NUMBER_OF_MOTORS];
    logic               frame_valid;
    logic        [7:0]  frame_motor;
    logic        [15:0] frames_ok;
    logic        [15:0] frames_dropped;

    modport master (
        output encoder0_position, encoder1_position, encoder0_velocity, encoder1_velocity,
        output current_phase1, current_phase2, current_phase3, error_code,
        output frame_valid, frame_motor, frames_ok, frames_dropped
    );

    modport slave (
        input encoder0_position, encoder1_position, encoder0_velocity, encoder1_velocity,
        input current_phase1, current_phase2, current_phase3, error_code,
        input frame_valid, frame_motor, frames_ok, frames_dropped
    );
endinterface

// File: rtl/status_frame_rx_uart_rx_byte.sv
// uart_rx_byte
// 8N1 UART byte receiver with a 2-flop input synchronizer.
//   clk, reset    : system clock, asynchronous active-high reset
//   rx_i          : UART line, idle high, asynchronous to clk
//   byte_data     : last received byte (valid while byte_valid pulses)
//   byte_valid    : one-cycle pulse at mid stop bit of a good byte
//   framing_error : one-cycle pulse at mid stop bit when the stop bit is low
module uart_rx_byte
    import status_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       framing_error
);
    localparam int             CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  BIT_M1   = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;

    // Synchronizer flops reset high so the idle line never looks like a start edge.
    // A start is only a high-to-low transition; a line stuck low after a bad stop
    // bit does not retrigger reception.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_prev       <= 1'b1;
            byte_data     <= '0;
            byte_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_meta       <= rx_i;
            rx_sync       <= rx_meta;
            rx_prev       <= rx_sync;
            byte_valid    <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_sync) state <= START;
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) state <= STOP;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_sync) begin
                            byte_data  <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/status_frame_rx.sv
// status_frame_rx
// Receives 35-byte status frames (SOF, motor id, 8 little-endian words, CRC-8)
// from the motor boards and commits each good frame atomically into the
// per-motor status arrays on the bus interface.
//   clk, reset : system clock, asynchronous active-high reset
//   rx_i       : UART line, idle high
//   bus        : status_frame_rx_if.master, per-motor status words and counters
// Optional feature macro: STATUS_RX_CRC_EN -- when defined the CRC byte is
// checked and a mismatch drops the frame; otherwise the CRC byte is received
// but ignored and no CRC logic is built.
module status_frame_rx
    import status_frame_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int CLOCK_FREQ_HZ    = 50_000_000,
    parameter int BAUDRATE         = 115200,
    parameter int TIMEOUT_BITS     = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_i,
    status_frame_rx_if.master bus
);
    localparam int             CLKS_PER_BIT   = CLOCK_FREQ_HZ / BAUDRATE;
    localparam int             TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int             TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMEOUT_LIMIT  = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]     MOTOR_LIMIT    = 8'(NUMBER_OF_MOTORS);

    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          framing_error;

    parser_state_e state;
    logic [7:0]    motor_id;
    logic [4:0]    byte_cnt;
    logic [TW-1:0] timer;
    logic [31:0]   stage [FRAME_WORDS];
    logic          abort;
    logic          crc_bad;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk           (clk),
        .reset         (reset),
        .rx_i          (rx_i),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .framing_error (framing_error)
    );

    // A byte arriving in the same cycle the gap limit is reached still counts.
    assign abort = framing_error || (timer >= TIMEOUT_LIMIT && !byte_valid);

`ifdef STATUS_RX_CRC_EN
    logic [7:0] crc_run;

    // Running CRC over motor id and payload; seeded fresh by the id byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_run <= '0;
        end else if (byte_valid) begin
            if (state == ID)           crc_run <= crc8_update(8'h00, byte_data);
            else if (state == PAYLOAD) crc_run <= crc8_update(crc_run, byte_data);
        end
    end

    assign crc_bad = (crc_run != byte_data);
`else
    assign crc_bad = 1'b0;
`endif

    // Frame parser. The payload is collected in a staging buffer and only
    // copied to the outputs in COMMIT, so an abandoned frame leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            motor_id <= '0;
            byte_cnt <= '0;
            timer    <= '0;
            for (int w = 0; w < FRAME_WORDS; w++) stage[w] <= '0;
            for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
                bus.encoder0_position[m] <= '0;
                bus.encoder1_position[m] <= '0;
                bus.encoder0_velocity[m] <= '0;
                bus.encoder1_velocity[m] <= '0;
                bus.current_phase1[m]    <= '0;
                bus.current_phase2[m]    <= '0;
                bus.current_phase3[m]    <= '0;
                bus.error_code[m]        <= '0;
            end
            bus.frame_valid    <= 1'b0;
            bus.frame_motor    <= '0;
            bus.frames_ok      <= '0;
            bus.frames_dropped <= '0;
        end else begin
            bus.frame_valid <= 1'b0;

            if (state == HUNT || byte_valid) timer <= '0;
            else                             timer <= timer + TW'(1);

            case (state)
                HUNT: begin
                    if (byte_valid && byte_data == SOF) state <= ID;
                end
                ID: begin
                    if (abort) begin
                        bus.frames_dropped <= bus.frames_dropped + 16'd1;
                        state              <= HUNT;
                    end else if (byte_valid) begin
                        motor_id <= byte_data;
                        byte_cnt <= '0;
                        state    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (abort) begin
                        bus.frames_dropped <= bus.frames_dropped + 16'd1;
                        state              <= HUNT;
                    end else if (byte_valid) begin
                        stage[byte_cnt[4:2]][{byte_cnt[1:0], 3'b000} +: 8] <= byte_data;
                        byte_cnt <= byte_cnt + 5'd1;
                        if (byte_cnt == 5'd31) state <= CRC;
                    end
                end
                CRC: begin
                    if (abort) begin
                        bus.frames_dropped <= bus.frames_dropped + 16'd1;
                        state              <= HUNT;
                    end else if (byte_valid) begin
                        if (motor_id >= MOTOR_LIMIT || crc_bad) begin
                            bus.frames_dropped <= bus.frames_dropped + 16'd1;
                            state              <= HUNT;
                        end else begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
                        if (motor_id == 8'(m)) begin
                            bus.encoder0_position[m] <= stage[F_ENC0_POS];
                            bus.encoder1_position[m] <= stage[F_ENC1_POS];
                            bus.encoder0_velocity[m] <= stage[F_ENC0_VEL];
                            bus.encoder1_velocity[m] <= stage[F_ENC1_VEL];
                            bus.current_phase1[m]    <= stage[F_PHASE1];
                            bus.current_phase2[m]    <= stage[F_PHASE2];
                            bus.current_phase3[m]    <= stage[F_PHASE3];
                            bus.error_code[m]        <= stage[F_ERROR];
                        end
                    end
                    bus.frame_valid <= 1'b1;
                    bus.frame_motor <= motor_id;
                    bus.frames_ok   <= bus.frames_ok + 16'd1;
                    state           <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_status_frame_rx.sv
// tb_status_frame_rx
// Drives serial status frames into status_frame_rx and compares every output
// against a frame-level reference model (per-motor word table plus counters).
module tb_status_frame_rx;
    import status_frame_pkg::*;

    localparam int N            = 6;
    localparam int CLK_HZ       = 1_000_000;
    localparam int BAUD         = 125_000;
    localparam int CPB          = CLK_HZ / BAUD;
    localparam int TIMEOUT_BITS = 20;

    logic clk = 1'b0;
    logic reset;
    logic rx_i;

    always #5 clk = ~clk;

    status_frame_rx_if #(.NUMBER_OF_MOTORS(N)) bus ();

    status_frame_rx #(
        .NUMBER_OF_MOTORS (N),
        .CLOCK_FREQ_HZ    (CLK_HZ),
        .BAUDRATE         (BAUD),
        .TIMEOUT_BITS     (TIMEOUT_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_i  (rx_i),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_word [N][FRAME_WORDS];
    logic [15:0] exp_ok;
    logic [15:0] exp_dropped;
    logic [7:0]  exp_motor;
    int          exp_pulses;
    int          fv_pulses;
    logic [31:0] frame_words [FRAME_WORDS];
    bit          crc_en;

    // Counting high cycles catches both missing pulses and stretched ones.
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] read_field(input int m, input int f);
        case (f)
            0:       return bus.encoder0_position[m];
            1:       return bus.encoder1_position[m];
            2:       return bus.encoder0_velocity[m];
            3:       return bus.encoder1_velocity[m];
            4:       return bus.current_phase1[m];
            5:       return bus.current_phase2[m];
            6:       return bus.current_phase3[m];
            default: return bus.error_code[m];
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < N; m++)
            for (int f = 0; f < FRAME_WORDS; f++) exp_word[m][f] = '0;
        exp_ok      = '0;
        exp_dropped = '0;
        exp_motor   = '0;
        exp_pulses  = 0;
    endtask

    // Frame-level outcome: a frame either lands whole in its slot or only bumps
    // the drop counter; a frame whose SOF never arrived leaves no trace at all.
    task automatic model_frame(input logic [7:0] id, input logic [7:0] crc_xor,
                               input int cut_at, input int bad_stop_at);
        exp_pulses = 0;
        if (cut_at == 0 || bad_stop_at == 0) return;
        if (cut_at > 0 || bad_stop_at > 0)       exp_dropped++;
        else if (int'(id) >= N)                 exp_dropped++;
        else if (crc_xor != 8'h00 && crc_en)    exp_dropped++;
        else begin
            for (int f = 0; f < FRAME_WORDS; f++) exp_word[id][f] = frame_words[f];
            exp_ok++;
            exp_motor  = id;
            exp_pulses = 1;
        end
    endtask

    task automatic check_all(input string ctx);
        checkOutput({ctx, ":frames_ok"},      32'(bus.frames_ok),      32'(exp_ok));
        checkOutput({ctx, ":frames_dropped"}, 32'(bus.frames_dropped), 32'(exp_dropped));
        checkOutput({ctx, ":frame_motor"},    32'(bus.frame_motor),    32'(exp_motor));
        checkOutput({ctx, ":valid_pulses"},   32'(fv_pulses),          32'(exp_pulses));
        checkOutput({ctx, ":frame_valid"},    32'(bus.frame_valid),    32'h0);
        for (int m = 0; m < N; m++)
            for (int f = 0; f < FRAME_WORDS; f++)
                checkOutput($sformatf("%s:m%0d.w%0d", ctx, m, f), read_field(m, f), exp_word[m][f]);
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx_i = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx_i = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Serialises SOF, id, frame_words and the CRC. cut_at stops the frame before
    // that byte with a long idle gap; bad_stop_at sends that byte with a low stop
    // bit and abandons the rest of the frame.
    task automatic applyStimulus(input logic [7:0] id, input logic [7:0] crc_xor,
                                 input int cut_at, input int bad_stop_at, input int gap_bits,
                                 input string ctx);
        logic [7:0] q[$];
        logic [7:0] crc;
        logic       fb;
        bit         done;
        fv_pulses = 0;
        q.push_back(SOF);
        q.push_back(id);
        for (int w = 0; w < FRAME_WORDS; w++)
            for (int k = 0; k < 4; k++) q.push_back(frame_words[w][8*k +: 8]);
        crc = 8'h00;
        for (int i = 1; i < q.size(); i++) begin
            for (int j = 7; j >= 0; j--) begin
                fb  = crc[7] ^ q[i][j];
                crc = {crc[6:0], 1'b0};
                if (fb) crc = crc ^ 8'h07;
            end
        end
        q.push_back(crc ^ crc_xor);
        done = 0;
        for (int i = 0; i < q.size() && !done; i++) begin
            if (i == cut_at) begin
                idle_bits(TIMEOUT_BITS + 5);
                done = 1;
            end else begin
                send_byte(q[i], i != bad_stop_at);
                if (i == bad_stop_at) begin
                    idle_bits(3);
                    done = 1;
                end else begin
                    idle_bits(gap_bits);
                end
            end
        end
        idle_bits(2);
        model_frame(id, crc_xor, cut_at, bad_stop_at);
        check_all(ctx);
    endtask

    task automatic random_words();
        for (int w = 0; w < FRAME_WORDS; w++) frame_words[w] = $urandom;
    endtask

    initial begin
        crc_en = 0;
`ifdef STATUS_RX_CRC_EN
        crc_en = 1;
`endif
        reset     = 1'b1;
        rx_i      = 1'b1;
        fv_pulses = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        idle_bits(2);

        $display("[TB] valid frame for motor 2");
        random_words();
        frame_words[F_ENC0_POS] = 32'h0000_1234;
        frame_words[F_ERROR]    = 32'hDEAD_BEEF;
        applyStimulus(8'd2, 8'h00, -1, -1, 0, "valid_m2");

        $display("[TB] same frame with corrupted CRC");
        applyStimulus(8'd2, 8'h01, -1, -1, 0, "bad_crc");

        $display("[TB] out-of-range motor id");
        random_words();
        applyStimulus(8'd6, 8'h00, -1, -1, 1, "bad_id");

        $display("[TB] idle gap after byte 10, then a good frame");
        random_words();
        applyStimulus(8'd4, 8'h00, 10, -1, 0, "timeout");
        random_words();
        applyStimulus(8'd4, 8'h00, -1, -1, 0, "after_timeout");

        $display("[TB] glitch and noise before SOF");
        fv_pulses = 0;
        rx_i = 1'b0;
        repeat (2) @(negedge clk);
        idle_bits(2);
        send_byte(8'h00, 1'b1);
        idle_bits(1);
        send_byte(8'hFF, 1'b1);
        idle_bits(2);
        exp_pulses = 0;
        check_all("noise");
        random_words();
        applyStimulus(8'd3, 8'h00, -1, -1, 0, "after_noise");

        $display("[TB] framing errors in hunt and mid-frame");
        fv_pulses = 0;
        send_byte(8'h5A, 1'b0);
        idle_bits(3);
        exp_pulses = 0;
        check_all("hunt_ferr");
        random_words();
        applyStimulus(8'd0, 8'h00, -1, 5, 0, "frame_ferr");

        $display("[TB] reset mid-payload");
        random_words();
        send_byte(SOF, 1'b1);
        send_byte(8'd1, 1'b1);
        for (int i = 0; i < 10; i++) send_byte(frame_words[i/4][8*(i%4) +: 8], 1'b1);
        reset = 1'b1;
        #1;
        fv_pulses = 0;
        model_reset();
        check_all("in_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle_bits(2);
        random_words();
        applyStimulus(8'd1, 8'h00, -1, -1, 0, "after_reset");

        $display("[TB] randomized frames");
        for (int n = 0; n < 10; n++) begin
            logic [7:0] id;
            logic [7:0] cx;
            int         mode;
            int         cut;
            int         bstop;
            id    = 8'($urandom_range(0, 7));
            cx    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            mode  = int'($urandom_range(0, 7));
            cut   = (mode == 0) ? int'($urandom_range(1, 34)) : -1;
            bstop = (mode == 1) ? int'($urandom_range(1, 34)) : -1;
            random_words();
            applyStimulus(id, cx, cut, bstop, int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
